// File: rtl/id_ex_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
package id_ex_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ALUOP_W        = 3;
  localparam int NUM_DATA       = 8;

  typedef struct packed {
    logic               regwrite;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               memwrite;
    logic               memread;
    logic               regstore;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_field_reg.sv
// Enable-gated register with asynchronous active-low clear; one per pipeline field group.
module id_ex_field_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/id_ex.sv
// ID/EX pipeline register: one-cycle capture of decode control and operands, stall by RegWrite=0.
// Optional bubble insertion on the control group when ID_EX_FLUSH_EN is defined.
module id_ex
  import id_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                RegWrite,
`ifdef ID_EX_FLUSH_EN
  input  logic                Flush,
`endif
  input  logic                IRegWrite,
  input  logic                IALUSrc,
  input  logic [ALUOP_W-1:0]  IALUOP,
  input  logic                IMemWrite,
  input  logic                IMemRead,
  input  logic                IRegStore,
  input  logic [DATA_W-1:0]   IPCP2,
  input  logic [DATA_W-1:0]   I1stArg,
  input  logic [DATA_W-1:0]   I2ndArg,
  input  logic [DATA_W-1:0]   I3rdArg,
  input  logic [DATA_W-1:0]   IImm,
  input  logic [DATA_W-1:0]   IRs1,
  input  logic [DATA_W-1:0]   IRs2,
  input  logic [DATA_W-1:0]   IRd,
  output logic                ORegWrite,
  output logic                OALUSrc,
  output logic [ALUOP_W-1:0]  OALUOP,
  output logic                OMemWrite,
  output logic                OMemRead,
  output logic                ORegStore,
  output logic [DATA_W-1:0]   OPCP2,
  output logic [DATA_W-1:0]   O1stArg,
  output logic [DATA_W-1:0]   O2ndArg,
  output logic [DATA_W-1:0]   O3rdArg,
  output logic [DATA_W-1:0]   OImm,
  output logic [DATA_W-1:0]   ORs1,
  output logic [DATA_W-1:0]   ORs2,
  output logic [DATA_W-1:0]   ORd
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic              ctrl_en;
  logic [DATA_W-1:0] din  [NUM_DATA];
  logic [DATA_W-1:0] dout [NUM_DATA];

  assign ctrl_in = {IRegWrite, IALUSrc, IALUOP, IMemWrite, IMemRead, IRegStore};

`ifdef ID_EX_FLUSH_EN
  // A flush zeroes the controls even during a stall so the bubble cannot write state.
  assign ctrl_en = RegWrite | Flush;
  assign ctrl_d  = Flush ? '0 : ctrl_in;
`else
  assign ctrl_en = RegWrite;
  assign ctrl_d  = ctrl_in;
`endif

  id_ex_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk   (CLK),
    .rst_n (Reset),
    .en    (ctrl_en),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  assign din[0] = IPCP2;
  assign din[1] = I1stArg;
  assign din[2] = I2ndArg;
  assign din[3] = I3rdArg;
  assign din[4] = IImm;
  assign din[5] = IRs1;
  assign din[6] = IRs2;
  assign din[7] = IRd;

  for (genvar i = 0; i < NUM_DATA; i++) begin : g_data
    id_ex_field_reg #(.W(DATA_W)) u_reg (
      .clk   (CLK),
      .rst_n (Reset),
      .en    (RegWrite),
      .d     (din[i]),
      .q     (dout[i])
    );
  end

  assign ORegWrite = ctrl_q.regwrite;
  assign OALUSrc   = ctrl_q.alusrc;
  assign OALUOP    = ctrl_q.aluop;
  assign OMemWrite = ctrl_q.memwrite;
  assign OMemRead  = ctrl_q.memread;
  assign ORegStore = ctrl_q.regstore;
  assign OPCP2     = dout[0];
  assign O1stArg   = dout[1];
  assign O2ndArg   = dout[2];
  assign O3rdArg   = dout[3];
  assign OImm      = dout[4];
  assign ORs1      = dout[5];
  assign ORs2      = dout[6];
  assign ORd       = dout[7];

endmodule

// File: tb/tb_id_ex.sv
// Self-checking bench for id_ex: directed sequences, a vector table and a randomized model comparison.
module tb_id_ex;

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic [2:0]  aluop;
    logic        memwrite;
    logic        memread;
    logic        regstore;
    logic [15:0] pcp2, a1, a2, a3, imm, rs1, rs2, rd;
  } f_t;

  typedef struct {
    logic rst;
    logic we;
    f_t   in;
    f_t   exp;
  } vec_t;

  logic CLK = 1'b0;
  logic Reset, RegWrite, Flush;
  f_t   inv, outv;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  id_ex #(.DATA_W(16)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
`ifdef ID_EX_FLUSH_EN
    .Flush     (Flush),
`endif
    .IRegWrite (inv.regwrite),
    .IALUSrc   (inv.alusrc),
    .IALUOP    (inv.aluop),
    .IMemWrite (inv.memwrite),
    .IMemRead  (inv.memread),
    .IRegStore (inv.regstore),
    .IPCP2     (inv.pcp2),
    .I1stArg   (inv.a1),
    .I2ndArg   (inv.a2),
    .I3rdArg   (inv.a3),
    .IImm      (inv.imm),
    .IRs1      (inv.rs1),
    .IRs2      (inv.rs2),
    .IRd       (inv.rd),
    .ORegWrite (outv.regwrite),
    .OALUSrc   (outv.alusrc),
    .OALUOP    (outv.aluop),
    .OMemWrite (outv.memwrite),
    .OMemRead  (outv.memread),
    .ORegStore (outv.regstore),
    .OPCP2     (outv.pcp2),
    .O1stArg   (outv.a1),
    .O2ndArg   (outv.a2),
    .O3rdArg   (outv.a3),
    .OImm      (outv.imm),
    .ORs1      (outv.rs1),
    .ORs2      (outv.rs2),
    .ORd       (outv.rd)
  );

  task automatic check(input string name, input f_t exp);
    checks++;
    if (outv !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, outv, exp);
    end
  endtask

  function automatic f_t rand_f();
    f_t v;
    v.regwrite = 1'($urandom);
    v.alusrc   = 1'($urandom);
    v.aluop    = 3'($urandom);
    v.memwrite = 1'($urandom);
    v.memread  = 1'($urandom);
    v.regstore = 1'($urandom);
    v.pcp2 = 16'($urandom); v.a1  = 16'($urandom);
    v.a2   = 16'($urandom); v.a3  = 16'($urandom);
    v.imm  = 16'($urandom); v.rs1 = 16'($urandom);
    v.rs2  = 16'($urandom); v.rd  = 16'($urandom);
    return v;
  endfunction

  // Reference behaviour of one rising edge: reset clears, enable loads, flush kills controls.
  function automatic f_t next_state(f_t cur, f_t in, logic rst, logic we, logic fl);
    f_t r;
    if (!rst) return '0;
    r = cur;
    if (we) r = in;
    if (fl) begin
      r.regwrite = 1'b0; r.alusrc = 1'b0; r.aluop = 3'b000;
      r.memwrite = 1'b0; r.memread = 1'b0; r.regstore = 1'b0;
    end
    return r;
  endfunction

  f_t   pa, pb, pz, flushed, model;
  vec_t tbl [7];
  logic rst_r, we_r, fl_r;

  initial begin
    pa = {1'b1, 1'b1, 3'b101, 1'b1, 1'b1, 1'b1,
          16'hA5A5, 16'h1234, 16'h5678, 16'h9ABC, 16'hFEDC, 16'h2468, 16'hBEEF, 16'hC0DE};
    pb = {1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0,
          16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    pz = '0;
    flushed = pa;
    flushed.regwrite = 1'b0; flushed.alusrc = 1'b0; flushed.aluop = 3'b000;
    flushed.memwrite = 1'b0; flushed.memread = 1'b0; flushed.regstore = 1'b0;

    tbl[0] = '{rst: 1'b0, we: 1'b1, in: pa, exp: pz};
    tbl[1] = '{rst: 1'b1, we: 1'b1, in: pa, exp: pa};
    tbl[2] = '{rst: 1'b1, we: 1'b0, in: pz, exp: pa};
    tbl[3] = '{rst: 1'b1, we: 1'b1, in: pb, exp: pb};
    tbl[4] = '{rst: 1'b1, we: 1'b0, in: pa, exp: pb};
    tbl[5] = '{rst: 1'b1, we: 1'b1, in: pz, exp: pz};
    tbl[6] = '{rst: 1'b1, we: 1'b1, in: pa, exp: pa};

    Reset = 1'b0; RegWrite = 1'b1; Flush = 1'b0; inv = pa;
    #1 check("reset_immediate", pz);
    @(posedge CLK); #1 check("reset_edge1", pz);
    @(posedge CLK); #1 check("reset_edge2", pz);

    @(negedge CLK); Reset = 1'b1;
    @(posedge CLK); #1 check("first_load", pa);

    @(negedge CLK); RegWrite = 1'b0; inv = pz;
    @(posedge CLK); #1 check("hold_edge1", pa);
    @(posedge CLK); #1 check("hold_edge2", pa);

    #3 Reset = 1'b0;
    #1 check("midcycle_reset", pz);
    @(negedge CLK); Reset = 1'b1; RegWrite = 1'b1; inv = pa;
    @(posedge CLK); #1 check("reload_after_reset", pa);

    inv = pb;
    #2 check("toggle_no_effect1", pa);
    inv = pz;
    #1 check("toggle_no_effect2", pa);
    inv = pb;
    @(posedge CLK); #1 check("toggle_capture", pb);

`ifdef ID_EX_FLUSH_EN
    @(negedge CLK); inv = pa; RegWrite = 1'b1; Flush = 1'b1;
    @(posedge CLK); #1 check("flush_load", flushed);
    @(negedge CLK); Flush = 1'b0;
    @(posedge CLK); #1 check("after_flush_load", pa);
    @(negedge CLK); inv = pb; RegWrite = 1'b0; Flush = 1'b1;
    @(posedge CLK); #1 check("flush_stall", flushed);
    @(negedge CLK); Flush = 1'b0;
`endif

    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      Reset = tbl[i].rst; RegWrite = tbl[i].we; inv = tbl[i].in;
      @(posedge CLK); #1 check($sformatf("table_%0d", i), tbl[i].exp);
    end

    model = pa;
    for (int i = 0; i < 250; i++) begin
      @(negedge CLK);
      rst_r = ($urandom_range(0, 15) != 0);
      we_r  = ($urandom_range(0, 3) != 0);
`ifdef ID_EX_FLUSH_EN
      fl_r  = ($urandom_range(0, 4) == 0);
`else
      fl_r  = 1'b0;
`endif
      Reset = rst_r; RegWrite = we_r; Flush = fl_r; inv = rand_f();
      #1;
      if (!rst_r) begin
        model = '0;
        check($sformatf("rand_async_%0d", i), model);
      end
      @(posedge CLK);
      model = next_state(model, inv, rst_r, we_r, fl_r);
      #1 check($sformatf("rand_%0d", i), model);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex.md
ID_EX -- requirements
Module: id_ex

Interface
REQ-001 Parameter: DATA_W, default 16, width of PC, argument, immediate and register-specifier fields.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; 0 clears all state.
REQ-004 RegWrite  input  1  stage load enable; 1 = capture inputs, 0 = hold (stall).
REQ-005 Flush  input  1  synchronous bubble insert (present only with ID_EX_FLUSH_EN).
REQ-006 IRegWrite / ORegWrite  in/out  1  register-file write control.
REQ-007 IALUSrc / OALUSrc  in/out  1  ALU operand-B select.
REQ-008 IALUOP / OALUOP  in/out  3  ALU operation code.
REQ-009 IMemWrite / OMemWrite  in/out  1  data-memory write control.
REQ-010 IMemRead / OMemRead  in/out  1  data-memory read control.
REQ-011 IRegStore / ORegStore  in/out  1  register-store control.
REQ-012 IPCP2 / OPCP2  in/out  DATA_W  PC+2.
REQ-013 I1stArg, I2ndArg, I3rdArg / O1stArg, O2ndArg, O3rdArg  in/out  DATA_W each  operand values.
REQ-014 IImm / OImm  in/out  DATA_W  immediate.
REQ-015 IRs1, IRs2, IRd / ORs1, ORs2, ORd  in/out  DATA_W each  register specifiers.

Function
REQ-016 Every O* output SHALL be driven directly from a flop, with no combinational path from any input.
REQ-017 Latency SHALL be one cycle: with Reset=1 and RegWrite=1, each O* SHALL equal its I* value sampled at the preceding rising CLK edge.
REQ-018 With RegWrite=0 at a rising edge, all outputs SHALL hold their previous values.
REQ-019 Control fields (ORegWrite, OALUSrc, OALUOP, OMemWrite, OMemRead, ORegStore) and data fields SHALL load together; no partial loads.
REQ-020 With Flush=1 at a rising edge, all control fields SHALL load 0 regardless of RegWrite, and data fields SHALL follow REQ-017/REQ-018.
REQ-021 Inputs changing between edges SHALL NOT affect outputs.

Reset
REQ-022 While Reset=0, every output SHALL be 0 immediately, independent of CLK, RegWrite and Flush.
REQ-023 On Reset deassertion, the first rising edge with RegWrite=1 SHALL load the inputs.
REQ-024 Reset asserted mid-operation SHALL clear all outputs within the same cycle, with no further edge required.

Configuration
REQ-025 Macro ID_EX_FLUSH_EN:
- Defined: the Flush port and REQ-020 exist.
- Undefined: no Flush port; the control fields behave exactly like the data fields.

Structure
REQ-026 A shared package id_ex_pkg SHALL hold DATA_W default, ALUOP width constant (3) and a packed control-field struct type.
REQ-027 A single sub-module id_ex_field_reg SHALL implement one parameterised-width async-reset, enable-gated register.
- It is instantiated once for the control group and once per data field.

Verification
REQ-028 Inputs set to 1,1,3'b101,1,1,1,A5A5,1234,5678,9ABC,FEDC,2468,BEEF,C0DE with Reset=0 -> all outputs 0 before and after CLK edges.
REQ-029 Same inputs, Reset=1, RegWrite=1, one rising edge -> every output equals its input.
REQ-030 Loaded state, RegWrite=0, inputs changed to 0000/0, two edges -> outputs keep A5A5..C0DE and controls 1.
REQ-031 Loaded state, Reset pulsed 0 mid-cycle between edges -> outputs 0 at once; after release plus one edge with RegWrite=1 -> reload inputs.
REQ-032 With ID_EX_FLUSH_EN, Flush=1, RegWrite=1, one edge -> all control outputs 0, OPCP2=A5A5 and other data equal inputs.
REQ-033 Inputs toggled between edges with RegWrite=1 -> outputs change only at rising CLK.
